mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Multicycle MIPS control FSM.
- Sequences fetch, decode, execute, memory and writeback, and drives the datapath mux and enable signals.
- Issues the 4-bit ALU operation code that the datapath ALU consumes. It also consumes the ALU Zero flag to decide branches.
- Sits between the instruction register and the datapath. Memory accesses use a ready handshake, so variable-latency memory stalls the FSM.

Parameters:
- ALU_AND, 4'b0000, ALU code for AND
- ALU_OR, 4'b0001, ALU code for OR
- ALU_ADD, 4'b0010, ALU code for add
- ALU_SUB, 4'b0110, ALU code for subtract
- ALU_SLT, 4'b0111, ALU code for set-less-than

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- Opcode  input  6  instruction register bits [31:26]
- Funct  input  6  instruction register bits [5:0]
- Zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  datapath controls
- ALUSrcB  output  2  00=B, 01=4, 10=sign-ext imm, 11=imm<<2
- PCSource  output  2  00=ALU out, 01=ALUOut register, 10=jump target
- ALUOperation  output  4  code to the ALU
- pc_en  output  1  PCWrite | (PCWriteCond & Zero)
- illegal_op  output  1  one-cycle pulse on unsupported opcode/funct
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction
- state  output  4  current state, for debug

Behaviour:
- State register is 4 bits, updated on posedge clk. reset=1 forces FETCH on the next edge.
- While reset=1, all write/enable outputs are forced to 0: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, pc_en, illegal_op, instr_done. Mux selects and ALUOperation are 0.
- Outputs are combinational from state; some are also gated by mem_ready. In every state, any control not listed below is 0. ALUOperation defaults to ALU_ADD.
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- Supported R-type funct values:
  - 100000 maps to ALU_ADD
  - 100010 maps to ALU_SUB
  - 100100 maps to ALU_AND
  - 100101 maps to ALU_OR
  - 101010 maps to ALU_SLT
- States and actions:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=00. IRWrite and PCWrite are asserted only when mem_ready=1. mem_ready=0: stay. mem_ready=1: go to DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ADD. Next state by opcode:
    - lw or sw: MEM_ADDR
    - R-type with a legal funct: EXECUTE
    - beq: BRANCH
    - j: JUMP
    - addi: ADDI_EXEC
    - anything else: illegal_op=1 and go to FETCH
  - MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ADD. lw goes to MEM_READ; sw goes to MEM_WRITE.
  - MEM_READ(3): MemRead=1, IorD=1. Stay until mem_ready=1, then go to MEM_WB.
  - MEM_WB(4): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Go to FETCH.
  - MEM_WRITE(5): MemWrite=1, IorD=1. Stay until mem_ready=1. On that cycle instr_done=1 and go to FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOperation decoded from Funct. Go to ALU_WB.
  - ALU_WB(7): RegDst=1, RegWrite=1, MemtoReg=0, instr_done=1. Go to FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond=1, PCSource=01, instr_done=1. Go to FETCH.
  - JUMP(9): PCWrite=1, PCSource=10, instr_done=1. Go to FETCH.
  - ADDI_EXEC(10): ALUSrcA=1, ALUSrcB=10, ADD. Go to ADDI_WB.
  - ADDI_WB(11): RegDst=0, RegWrite=1, MemtoReg=0, instr_done=1. Go to FETCH.
  - Codes 12-15 are unreachable. If entered, go to FETCH with illegal_op=1.
- Latency in cycles with mem_ready held at 1: R-type 4, lw 5, sw 4, addi 4, beq 3, j 3. Each stall cycle adds one.
- Opcode and Funct must be stable from DECODE through writeback, because the IR is written only in FETCH.
- MemRead and MemWrite are never both 1. At most one of RegWrite, MemWrite or IRWrite is 1 in any cycle.
- Reset in any state, including a stalled memory state: the next state is FETCH and no write enable is asserted during the reset cycle.

Test Plan:
- Reset: hold reset 2 cycles, then release with mem_ready=1 -> state=0 and MemRead=1; IRWrite=PCWrite=1 in the first cycle; state=1 next cycle.
- R-type add (Opcode=000000, Funct=100000), mem_ready=1 -> states 0,1,6,7; ALUOperation=0010 in state 6; RegWrite=RegDst=1 in state 7; instr_done pulses once.
- lw with mem_ready low for 2 extra cycles in MEM_READ -> states 0,1,2,3,3,3,4; MemRead=IorD=1 throughout MEM_READ; MemtoReg=RegWrite=1 in state 4.
- beq (Opcode=000100): Zero=1 -> pc_en=1 and PCSource=01 in state 8; Zero=0 -> pc_en=0; ALUOperation=0110 in both cases.
- Illegal opcode 111111, and R-type with Funct=000000 -> illegal_op=1 for exactly one cycle in DECODE, then state=0; RegWrite and MemWrite never assert.
- sw stalled in MEM_WRITE with mem_ready=0, then reset=1 -> MemWrite=0 during the reset cycle; state=0 after; a subsequent j (000010) completes in 3 cycles with PCWrite=1 and PCSource=10.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control_if
//
// Bundles the signals between the multicycle MIPS control FSM and the
// datapath / instruction register / memory.
//
//   Opcode[5:0], Funct[5:0] : instruction register fields (IR[31:26], IR[5:0])
//   Zero                    : ALU zero flag, used for beq
//   mem_ready               : memory completes the current access this cycle
//   PCWrite .. ALUSrcA      : single-bit datapath controls
//   ALUSrcB[1:0]            : 00=B, 01=4, 10=sign-ext imm, 11=imm<<2
//   PCSource[1:0]           : 00=ALU out, 01=ALUOut register, 10=jump target
//   ALUOperation[3:0]       : operation code consumed by the ALU
//   pc_en                   : PCWrite | (PCWriteCond & Zero)
//   illegal_op              : one-cycle pulse on unsupported opcode/funct
//   instr_done              : one-cycle pulse on the last cycle of an instruction
//   state[3:0]              : current FSM state, debug only
//
// master : the control FSM (drives the controls)
// slave  : the datapath side (drives IR fields, Zero and mem_ready)
// ---------------------------------------------------------------------------
interface mips_multicycle_control_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [3:0] ALUOperation;
    logic       pc_en;
    logic       illegal_op;
    logic       instr_done;
    logic [3:0] state;

    modport master (
        input  Opcode, Funct, Zero, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               ALUOperation, pc_en, illegal_op, instr_done, state
    );

    modport slave (
        output Opcode, Funct, Zero, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               ALUOperation, pc_en, illegal_op, instr_done, state
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control
//
// Multicycle MIPS control FSM: fetch, decode, execute, memory, writeback.
// Supports R-type (add/sub/and/or/slt), lw, sw, beq, addi and j. Memory
// states wait on mem_ready, so variable-latency memory simply stalls here.
//
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high; next state is FETCH and every write /
//           enable output is held low while it is asserted
//   bus   : master side of mips_multicycle_control_if (IR fields, Zero,
//           mem_ready in; all datapath controls, pc_en, illegal_op,
//           instr_done and debug state out)
//
// Outputs are combinational from the state register (plus mem_ready in the
// memory states and Zero for pc_en).
// ---------------------------------------------------------------------------
module mips_multicycle_control #(
    parameter logic [3:0] ALU_AND = 4'b0000,
    parameter logic [3:0] ALU_OR  = 4'b0001,
    parameter logic [3:0] ALU_ADD = 4'b0010,
    parameter logic [3:0] ALU_SUB = 4'b0110,
    parameter logic [3:0] ALU_SLT = 4'b0111
) (
    input  logic                          clk,
    input  logic                          reset,
    mips_multicycle_control_if.master     bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic       illegal;
    logic       done;

    logic       funct_legal;
    logic [3:0] funct_alu_op;

    // R-type funct decode, shared by DECODE (legality) and EXECUTE (ALU op).
    always_comb begin
        funct_legal  = 1'b1;
        funct_alu_op = ALU_ADD;
        case (bus.Funct)
            6'b100000: funct_alu_op = ALU_ADD;
            6'b100010: funct_alu_op = ALU_SUB;
            6'b100100: funct_alu_op = ALU_AND;
            6'b100101: funct_alu_op = ALU_OR;
            6'b101010: funct_alu_op = ALU_SLT;
            default:   funct_legal  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = ALU_ADD;
        illegal       = 1'b0;
        done          = 1'b0;
        state_d       = state_q;

        case (state_q)
            S_FETCH: begin
                // PC+4 is computed every cycle; PC and IR only latch once
                // memory actually delivers the instruction.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target (PC + imm<<2) is precomputed into ALUOut.
                alu_src_b = 2'b11;
                case (bus.Opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE: begin
                        if (funct_legal) begin
                            state_d = S_EXECUTE;
                        end else begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_J:    state_d = S_JUMP;
                    OP_ADDI: state_d = S_ADDI_EXEC;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (bus.Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                done       = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (bus.mem_ready) begin
                    done    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = funct_alu_op;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                done      = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                done          = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                done      = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                done      = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                // Codes 12-15: recover to FETCH and flag it.
                illegal = 1'b1;
                state_d = S_FETCH;
            end
        endcase

        // Reset overrides everything so no write fires during the reset
        // cycle, even from a stalled memory state.
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            pc_source     = 2'b00;
            alu_op        = 4'b0000;
            illegal       = 1'b0;
            done          = 1'b0;
            state_d       = S_FETCH;
        end
    end

    assign bus.PCWrite      = pc_write;
    assign bus.PCWriteCond  = pc_write_cond;
    assign bus.IorD         = iord;
    assign bus.MemRead      = mem_read;
    assign bus.MemWrite     = mem_write;
    assign bus.IRWrite      = ir_write;
    assign bus.MemtoReg     = mem_to_reg;
    assign bus.RegDst       = reg_dst;
    assign bus.RegWrite     = reg_write;
    assign bus.ALUSrcA      = alu_src_a;
    assign bus.ALUSrcB      = alu_src_b;
    assign bus.PCSource     = pc_source;
    assign bus.ALUOperation = alu_op;
    assign bus.pc_en        = pc_write | (pc_write_cond & bus.Zero);
    assign bus.illegal_op   = illegal;
    assign bus.instr_done   = done;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_control
//
// Directed bench for the multicycle MIPS control FSM. Every check compares a
// packed snapshot of all outputs:
//   {state[3:0],
//    PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//    RegDst, RegWrite, ALUSrcA,
//    ALUSrcB[1:0], PCSource[1:0], ALUOperation[3:0],
//    pc_en, illegal_op, instr_done}
// against a hand-written expected value.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_control;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    logic [24:0] got;
    logic [24:0] exp_v;

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] obs();
        return {bus.state, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
                bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALUOperation,
                bus.pc_en, bus.illegal_op, bus.instr_done};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.mem_ready = 1'b0; bus.Zero = 1'b0;
        bus.Opcode = 6'b000000; bus.Funct = 6'b100000;
        tick(); tick();
        exp_v = {4'd0, 21'b0};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL reset_hold got %b exp %b", got, exp_v); end
        reset = 1'b0; bus.mem_ready = 1'b1; #1;
        exp_v = {4'd0, 10'b1001010000, 2'b01, 2'b00, 4'b0010, 3'b100};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL reset_first_fetch got %b exp %b", got, exp_v); end
        tick();
        exp_v = {4'd1, 10'b0, 2'b11, 2'b00, 4'b0010, 3'b000};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL reset_decode got %b exp %b", got, exp_v); end
    endtask

    task automatic test_rtype_add();
        do_reset();
        bus.Opcode = 6'b000000; bus.Funct = 6'b100000; bus.mem_ready = 1'b1; #1;
        tick();
        exp_v = {4'd1, 10'b0, 2'b11, 2'b00, 4'b0010, 3'b000};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL radd_decode got %b exp %b", got, exp_v); end
        tick();
        exp_v = {4'd6, 10'b0000000001, 2'b00, 2'b00, 4'b0010, 3'b000};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL radd_execute got %b exp %b", got, exp_v); end
        tick();
        exp_v = {4'd7, 10'b0000000110, 2'b00, 2'b00, 4'b0010, 3'b001};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL radd_alu_wb got %b exp %b", got, exp_v); end
        tick();
        exp_v = {4'd0, 10'b1001010000, 2'b01, 2'b00, 4'b0010, 3'b100};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL radd_back_fetch got %b exp %b", got, exp_v); end
    endtask

    task automatic test_lw_stall();
        do_reset();
        bus.Opcode = 6'b100011; bus.mem_ready = 1'b0; #1;
        exp_v = {4'd0, 10'b0001000000, 2'b01, 2'b00, 4'b0010, 3'b000};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL lw_fetch_stall got %b exp %b", got, exp_v); end
        tick();
        bus.mem_ready = 1'b1; #1;
        exp_v = {4'd0, 10'b1001010000, 2'b01, 2'b00, 4'b0010, 3'b100};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL lw_fetch got %b exp %b", got, exp_v); end
        tick(); tick();
        exp_v = {4'd2, 10'b0000000001, 2'b10, 2'b00, 4'b0010, 3'b000};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL lw_mem_addr got %b exp %b", got, exp_v); end
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = (i == 2); #1;
            exp_v = {4'd3, 10'b0011000000, 2'b00, 2'b00, 4'b0010, 3'b000};
            got = obs(); n_vec++;
            if (got !== exp_v) begin n_err++; $display("FAIL lw_mem_read[%0d] got %b exp %b", i, got, exp_v); end
            tick();
        end
        exp_v = {4'd4, 10'b0000001010, 2'b00, 2'b00, 4'b0010, 3'b001};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL lw_mem_wb got %b exp %b", got, exp_v); end
        tick();
        got = obs(); n_vec++;
        if (got[24:21] !== 4'd0) begin n_err++; $display("FAIL lw_back_fetch state got %0d exp 0", got[24:21]); end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            do_reset();
            bus.Opcode = 6'b000100; bus.mem_ready = 1'b1; bus.Zero = z[0]; #1;
            tick(); tick();
            exp_v = {4'd8, 10'b0100000001, 2'b00, 2'b01, 4'b0110, z[0], 2'b01};
            got = obs(); n_vec++;
            if (got !== exp_v) begin n_err++; $display("FAIL beq_zero%0d got %b exp %b", z, got, exp_v); end
            tick();
            got = obs(); n_vec++;
            if (got[24:21] !== 4'd0) begin n_err++; $display("FAIL beq_zero%0d_next state got %0d exp 0", z, got[24:21]); end
        end
        bus.Zero = 1'b0;
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2];
        logic [5:0] fns [2];
        ops[0] = 6'b111111; fns[0] = 6'b100000;
        ops[1] = 6'b000000; fns[1] = 6'b000000;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            bus.Opcode = ops[k]; bus.Funct = fns[k]; bus.mem_ready = 1'b1; #1;
            tick();
            exp_v = {4'd1, 10'b0, 2'b11, 2'b00, 4'b0010, 3'b010};
            got = obs(); n_vec++;
            if (got !== exp_v) begin n_err++; $display("FAIL illegal%0d_decode got %b exp %b", k, got, exp_v); end
            tick();
            exp_v = {4'd0, 10'b1001010000, 2'b01, 2'b00, 4'b0010, 3'b100};
            got = obs(); n_vec++;
            if (got !== exp_v) begin n_err++; $display("FAIL illegal%0d_fetch got %b exp %b", k, got, exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] fn [5];
        logic [3:0] ao [5];
        fn[0] = 6'b100000; ao[0] = 4'b0010;
        fn[1] = 6'b100010; ao[1] = 4'b0110;
        fn[2] = 6'b100100; ao[2] = 4'b0000;
        fn[3] = 6'b100101; ao[3] = 4'b0001;
        fn[4] = 6'b101010; ao[4] = 4'b0111;
        do_reset();
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.Opcode = 6'b000000; bus.Funct = fn[i]; #1;
            tick(); tick();
            exp_v = {4'd6, 10'b0000000001, 2'b00, 2'b00, ao[i], 3'b000};
            got = obs(); n_vec++;
            if (got !== exp_v) begin n_err++; $display("FAIL b2b_exec_funct%b got %b exp %b", fn[i], got, exp_v); end
            tick(); tick();
        end
        bus.Opcode = 6'b001000; #1;
        tick(); tick();
        exp_v = {4'd10, 10'b0000000001, 2'b10, 2'b00, 4'b0010, 3'b000};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL addi_exec got %b exp %b", got, exp_v); end
        tick();
        exp_v = {4'd11, 10'b0000000010, 2'b00, 2'b00, 4'b0010, 3'b001};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL addi_wb got %b exp %b", got, exp_v); end
        tick();
        bus.Opcode = 6'b101011; #1;
        tick(); tick(); tick();
        exp_v = {4'd5, 10'b0010100000, 2'b00, 2'b00, 4'b0010, 3'b001};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL sw_write_ready got %b exp %b", got, exp_v); end
        tick();
        got = obs(); n_vec++;
        if (got[24:21] !== 4'd0) begin n_err++; $display("FAIL sw_back_fetch state got %0d exp 0", got[24:21]); end
    endtask

    task automatic test_sw_reset_jump();
        do_reset();
        bus.Opcode = 6'b101011; bus.mem_ready = 1'b1; #1;
        tick(); tick(); tick();
        bus.mem_ready = 1'b0; #1;
        for (int i = 0; i < 2; i++) begin
            exp_v = {4'd5, 10'b0010100000, 2'b00, 2'b00, 4'b0010, 3'b000};
            got = obs(); n_vec++;
            if (got !== exp_v) begin n_err++; $display("FAIL sw_stall[%0d] got %b exp %b", i, got, exp_v); end
            tick();
        end
        reset = 1'b1; #1;
        exp_v = {4'd5, 21'b0};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL sw_reset_cycle got %b exp %b", got, exp_v); end
        tick();
        reset = 1'b0; bus.Opcode = 6'b000010; bus.mem_ready = 1'b1; #1;
        exp_v = {4'd0, 10'b1001010000, 2'b01, 2'b00, 4'b0010, 3'b100};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL j_fetch got %b exp %b", got, exp_v); end
        tick();
        exp_v = {4'd1, 10'b0, 2'b11, 2'b00, 4'b0010, 3'b000};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL j_decode got %b exp %b", got, exp_v); end
        tick();
        exp_v = {4'd9, 10'b1000000000, 2'b00, 2'b10, 4'b0010, 3'b101};
        got = obs(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL j_jump got %b exp %b", got, exp_v); end
        tick();
        got = obs(); n_vec++;
        if (got[24:21] !== 4'd0) begin n_err++; $display("FAIL j_back_fetch state got %0d exp 0", got[24:21]); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.Opcode = 6'b0; bus.Funct = 6'b0; bus.Zero = 1'b0; bus.mem_ready = 1'b0;
        test_reset();
        test_rtype_add();
        test_lw_stall();
        test_beq();
        test_illegal();
        test_back_to_back();
        test_sw_reset_jump();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
